// File: rtl/peak_pkg.sv
// Shared definitions for the peak detector.
//   ADDR_W, DATA_W, MAX_PEAKS : default frame/sample/table geometry
//   state_t                   : scan controller states
//   peak_entry_t              : one ranked table record {pos, val}
// The entry record is sized by the package constants, so module parameters
// overriding ADDR_W/DATA_W must be kept equal to the values here.
package peak_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 12;
    localparam int MAX_PEAKS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pos;
        logic [DATA_W-1:0] val;
    } peak_entry_t;

endpackage

// File: rtl/peak_if.sv
// Bus bundle between the peak detector and its environment.
//   detect_start / detect_finish : run control level handshake
//   bram_rd_addr / bram_rd_data  : sample memory read port (1-cycle latency)
//   peak_idx / peak_pos / peak_val / detect_peak_num : ranked result read port
// modport master : the detector side
// modport slave  : the system side (memory, run control, display control)
interface peak_if #(
    parameter int ADDR_W = peak_pkg::ADDR_W,
    parameter int DATA_W = peak_pkg::DATA_W
);
    import peak_pkg::*;

    logic              detect_start;
    logic              detect_finish;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [DATA_W-1:0] bram_rd_data;
    logic [2:0]        detect_peak_num;
    logic [2:0]        peak_idx;
    logic [ADDR_W-1:0] peak_pos;
    logic [DATA_W-1:0] peak_val;

    modport master (
        input  detect_start,
        input  bram_rd_data,
        input  peak_idx,
        output detect_finish,
        output bram_rd_addr,
        output detect_peak_num,
        output peak_pos,
        output peak_val
    );

    modport slave (
        output detect_start,
        output bram_rd_data,
        output peak_idx,
        input  detect_finish,
        input  bram_rd_addr,
        input  detect_peak_num,
        input  peak_pos,
        input  peak_val
    );

endinterface

// File: rtl/peak_topk.sv
// Ranked peak table: keeps the MAX_PEAKS largest candidates sorted by value,
// descending, with equal values ranked by arrival order (earlier address first).
//   clk, rst   : clock, synchronous active-high reset
//   clear      : empties the table and count
//   insert     : candidate {cand_pos, cand_val} offered this cycle
//   rd_idx     : rank to read, 0 = largest
//   count      : number of valid entries, saturates at MAX_PEAKS
//   rd_pos/val : selected entry, 0 when rd_idx is not a valid rank
module peak_topk #(
    parameter int ADDR_W    = peak_pkg::ADDR_W,
    parameter int DATA_W    = peak_pkg::DATA_W,
    parameter int MAX_PEAKS = peak_pkg::MAX_PEAKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              insert,
    input  logic [ADDR_W-1:0] cand_pos,
    input  logic [DATA_W-1:0] cand_val,
    input  logic [2:0]        rd_idx,
    output logic [2:0]        count,
    output logic [ADDR_W-1:0] rd_pos,
    output logic [DATA_W-1:0] rd_val
);
    import peak_pkg::*;

    peak_entry_t          entries      [MAX_PEAKS];
    peak_entry_t          entries_next [MAX_PEAKS];
    peak_entry_t          cand;
    logic [MAX_PEAKS-1:0] keeps;
    logic                 accept;

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c == 3'(MAX_PEAKS)) ? c : c + 3'd1;
    endfunction

    assign cand.pos = cand_pos;
    assign cand.val = cand_val;

    // An entry keeps its slot when it is valid and ranks at or above the
    // candidate; ">=" makes an equal, later-arriving candidate rank below.
    // Valid entries form a sorted prefix, so keeps is a run of ones.
    always_comb begin
        for (int j = 0; j < MAX_PEAKS; j++) begin
            keeps[j] = (3'(j) < count) && (entries[j].val >= cand_val);
        end
    end

    // Nothing below the last slot outranks the candidate -> it enters the
    // table, and an empty or larger-than-last slot exists.
    assign accept = insert && !keeps[MAX_PEAKS-1];

    always_comb begin
        entries_next[0] = keeps[0] ? entries[0] : cand;
        for (int j = 1; j < MAX_PEAKS; j++) begin
            if (keeps[j]) begin
                entries_next[j] = entries[j];
            end else if (keeps[j-1]) begin
                entries_next[j] = cand;
            end else begin
                entries_next[j] = entries[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int j = 0; j < MAX_PEAKS; j++) begin
                entries[j] <= '0;
            end
            count <= '0;
        end else if (accept) begin
            for (int j = 0; j < MAX_PEAKS; j++) begin
                entries[j] <= entries_next[j];
            end
            count <= sat_inc(count);
        end
    end

    // Ranks at or beyond the valid count (including 7 from display control)
    // never match and read as zero.
    always_comb begin
        rd_pos = '0;
        rd_val = '0;
        for (int j = 0; j < MAX_PEAKS; j++) begin
            if ((rd_idx == 3'(j)) && (3'(j) < count)) begin
                rd_pos = entries[j].pos;
                rd_val = entries[j].val;
            end
        end
    end

endmodule

// File: rtl/peak_detect.sv
// Frame peak detector: on a rising edge of detect_start, reads one frame of
// 2**ADDR_W samples from BRAM, finds interior local maxima (plateaus counted
// once at their left edge) and ranks the MAX_PEAKS largest in peak_topk.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : peak_if master (run handshake, BRAM read port, result read port)
module peak_detect #(
    parameter int ADDR_W    = peak_pkg::ADDR_W,
    parameter int DATA_W    = peak_pkg::DATA_W,
    parameter int MAX_PEAKS = peak_pkg::MAX_PEAKS
) (
    input  logic   clk,
    input  logic   rst,
    peak_if.master bus
);
    import peak_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    function automatic logic is_peak(input logic [DATA_W-1:0] prev,
                                     input logic [DATA_W-1:0] mid,
                                     input logic [DATA_W-1:0] succ);
        return (prev < mid) && (mid >= succ);
    endfunction

    state_t            state;
    state_t            state_next;
    logic              start_q;
    logic              armed;
    logic              start_edge;
    logic              clear;
    logic [ADDR_W-1:0] rd_addr;

    logic              vld_p0;
    logic              vld_p1;
    logic [ADDR_W-1:0] pos_p1;
    logic              vld_p2;
    logic [ADDR_W-1:0] pos_p2;
    logic [DATA_W-1:0] prev_p2;
    logic [DATA_W-1:0] mid_p2;
    logic [DATA_W-1:0] succ_p2;

    logic              cand_vld;
    logic [ADDR_W-1:0] cand_pos;
    logic [2:0]        peak_count;
    logic [ADDR_W-1:0] sel_pos;
    logic [DATA_W-1:0] sel_val;

    // armed stays low after reset until detect_start is seen low, so a start
    // level already high at reset release is not taken as a new run.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= bus.detect_start;
            if (!bus.detect_start) begin
                armed <= 1'b1;
            end
        end
    end

    assign start_edge = bus.detect_start && !start_q && armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // clear empties the table on a new run and on an abort; it also flushes
    // the read pipeline so an aborted frame cannot insert late candidates.
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_next = SCAN;
                    clear      = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.detect_start) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (rd_addr == LAST_ADDR) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.detect_start) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (vld_p2 && (pos_p2 == LAST_ADDR)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.detect_start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if ((state == SCAN) && (state_next == SCAN)) begin
            rd_addr <= rd_addr + ADDR_W'(1);
        end else begin
            rd_addr <= '0;
        end
    end

    assign vld_p0 = (state == SCAN);

    // ---- p0 -> p1 : address issued, BRAM returns its sample next cycle ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && !clear;
        end
    end

    always_ff @(posedge clk) begin
        pos_p1 <= rd_addr;
    end

    // ---- p1 -> p2 : returned sample shifts into the 3-sample window ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            prev_p2 <= '0;
            mid_p2  <= '0;
            succ_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1 && !clear;
            if (vld_p1) begin
                prev_p2 <= mid_p2;
                mid_p2  <= succ_p2;
                succ_p2 <= bus.bram_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            pos_p2 <= pos_p1;
        end
    end

    // ---- p2 : evaluate centre sample, insert into the ranked table ----
    // pos_p2 tracks the newest sample; requiring it >= 2 keeps the window
    // entirely inside the current frame and excludes address 0 as a centre.
    // The newest sample never exceeds N-1, so N-1 is never a centre either.
    assign cand_pos = pos_p2 - ADDR_W'(1);
    assign cand_vld = vld_p2
                   && (pos_p2 >= ADDR_W'(2))
                   && is_peak(prev_p2, mid_p2, succ_p2)
                   && ((state == SCAN) || (state == DRAIN));

    peak_topk #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_PEAKS (MAX_PEAKS)
    ) u_topk (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .insert   (cand_vld),
        .cand_pos (cand_pos),
        .cand_val (mid_p2),
        .rd_idx   (bus.peak_idx),
        .count    (peak_count),
        .rd_pos   (sel_pos),
        .rd_val   (sel_val)
    );

    assign bus.detect_finish   = (state == DONE);
    assign bus.bram_rd_addr    = rd_addr;
    assign bus.detect_peak_num = peak_count;
    assign bus.peak_pos        = sel_pos;
    assign bus.peak_val        = sel_val;

endmodule

// File: tb/tb_peak_detect.sv
// Self-checking bench for peak_detect: directed frames with literal expected
// results plus randomized frames, all compared against a reference that lists
// every interior local maximum and selects the largest by value/address.
module tb_peak_detect;

    localparam int AW = 10;
    localparam int DW = 12;
    localparam int MP = 6;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [DW-1:0] mem [N];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int exp_num;
    int exp_pos [8];
    int exp_val [8];

    peak_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    peak_detect #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEAKS(MP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always_ff @(posedge clk) bus.bram_rd_data <= mem[bus.bram_rd_addr];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: collect all peaks in address order, then pick the best
    // MP of them (largest value, earliest address on ties).
    task automatic build_model();
        int  cpos [$];
        int  cval [$];
        bit  used [$];
        int  best;
        cpos.delete(); cval.delete(); used.delete();
        for (int i = 1; i <= N - 2; i++) begin
            if (mem[i-1] < mem[i] && mem[i] >= mem[i+1]) begin
                cpos.push_back(i);
                cval.push_back(int'(mem[i]));
                used.push_back(1'b0);
            end
        end
        exp_num = 0;
        for (int r = 0; r < 8; r++) begin
            exp_pos[r] = 0;
            exp_val[r] = 0;
        end
        for (int r = 0; r < MP; r++) begin
            best = -1;
            for (int k = 0; k < cpos.size(); k++) begin
                if (!used[k] && (best < 0 || cval[k] > cval[best])) best = k;
            end
            if (best >= 0) begin
                used[best] = 1'b1;
                exp_pos[r] = cpos[best];
                exp_val[r] = cval[best];
                exp_num++;
            end
        end
    endtask

    // Per-cycle comparison of the result port while results are meaningful.
    always @(negedge clk) begin
        if (chk_en) begin
            int i;
            i = int'(bus.peak_idx);
            check("num", int'(bus.detect_peak_num), exp_num);
            check("pos", int'(bus.peak_pos), exp_pos[i]);
            check("val", int'(bus.peak_val), exp_val[i]);
        end
    end

    task automatic fill_const(input int v);
        for (int a = 0; a < N; a++) mem[a] = DW'(v);
    endtask

    task automatic fill_random(input int mode);
        int walk;
        walk = 2048;
        for (int a = 0; a < N; a++) begin
            case (mode)
                0: mem[a] = DW'($urandom_range(0, 4095));
                1: mem[a] = DW'($urandom_range(0, 3));
                2: mem[a] = ($urandom_range(0, 15) == 0) ? DW'(16 * $urandom_range(1, 8)) : '0;
                default: begin
                    walk = walk + int'($urandom_range(0, 64)) - 32;
                    if (walk < 0) walk = 0;
                    if (walk > 4095) walk = 4095;
                    mem[a] = DW'(walk);
                end
            endcase
        end
    endtask

    // Start a frame with a fresh rising edge and wait (bounded) for finish,
    // checking the address sequence on the way. Leaves detect_start high.
    task automatic run_frame();
        bit addr_ok;
        bit seen;
        int lat;
        int want;
        build_model();
        bus.detect_start = 1'b0;
        tick(); tick();
        bus.detect_start = 1'b1;
        addr_ok = 1'b1;
        seen    = 1'b0;
        lat     = 0;
        for (int cyc = 1; cyc <= N + 12 && !seen; cyc++) begin
            tick();
            want = (cyc <= N) ? cyc - 1 : 0;
            if (bus.bram_rd_addr !== AW'(want)) addr_ok = 1'b0;
            if (bus.detect_finish === 1'b1) begin
                seen = 1'b1;
                lat  = cyc - 1;
            end
        end
        check("addr_seq", int'(addr_ok), 1);
        check("finish_seen", int'(seen), 1);
        check("latency_le_n4", (seen && lat <= N + 4) ? 1 : 0, 1);
    endtask

    task automatic read_lit(input string name, input int idx, input int pos, input int val);
        bus.peak_idx = 3'(idx);
        #1;
        check({name, "_pos"}, int'(bus.peak_pos), pos);
        check({name, "_val"}, int'(bus.peak_val), val);
    endtask

    // Sweep every rank in DONE, drop start, sweep again in IDLE.
    task automatic sweep_and_release();
        chk_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.peak_idx = 3'(i);
            tick();
        end
        bus.detect_start = 1'b0;
        tick();
        check("finish_fall", int'(bus.detect_finish), 0);
        check("addr_idle", int'(bus.bram_rd_addr), 0);
        for (int i = 0; i < 8; i++) begin
            bus.peak_idx = 3'(i);
            tick();
        end
        chk_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit fin;
        bit bad;

        rst = 1'b1;
        bus.detect_start = 1'b1;
        bus.peak_idx = 3'd0;
        fill_const(0);
        tick(); tick(); tick();
        check("rst_finish", int'(bus.detect_finish), 0);
        check("rst_addr", int'(bus.bram_rd_addr), 0);
        check("rst_num", int'(bus.detect_peak_num), 0);
        check("rst_pos", int'(bus.peak_pos), 0);
        check("rst_val", int'(bus.peak_val), 0);

        // start already high at reset release must not launch a scan
        rst = 1'b0;
        repeat (5) tick();
        check("no_scan_after_rst_addr", int'(bus.bram_rd_addr), 0);
        check("no_scan_after_rst_fin", int'(bus.detect_finish), 0);

        // flat frame
        fill_const(12'h100);
        run_frame();
        check("flat_model_num", exp_num, 0);
        check("flat_num", int'(bus.detect_peak_num), 0);
        read_lit("flat_idx0", 0, 0, 0);
        sweep_and_release();

        // single spike
        fill_const(0);
        mem[100] = 12'h800;
        run_frame();
        check("spike_model_num", exp_num, 1);
        check("spike_model_pos", exp_pos[0], 100);
        check("spike_num", int'(bus.detect_peak_num), 1);
        read_lit("spike_idx0", 0, 100, 12'h800);
        read_lit("spike_idx1", 1, 0, 0);
        sweep_and_release();

        // eight spikes, table overflow
        fill_const(0);
        for (int k = 1; k <= 8; k++) mem[10 * k] = DW'(16 * k);
        run_frame();
        check("eight_model_num", exp_num, 6);
        check("eight_model_val5", exp_val[5], 12'h30);
        check("eight_num", int'(bus.detect_peak_num), 6);
        read_lit("eight_idx0", 0, 80, 12'h80);
        read_lit("eight_idx5", 5, 30, 12'h30);
        read_lit("eight_idx6", 6, 0, 0);
        read_lit("eight_idx7", 7, 0, 0);
        sweep_and_release();

        // plateau plus equal spike
        fill_const(0);
        mem[50] = 12'h200; mem[51] = 12'h200; mem[52] = 12'h200;
        mem[300] = 12'h200;
        run_frame();
        check("plat_model_num", exp_num, 2);
        check("plat_num", int'(bus.detect_peak_num), 2);
        read_lit("plat_idx0", 0, 50, 12'h200);
        read_lit("plat_idx1", 1, 300, 12'h200);
        sweep_and_release();

        // spikes only at the frame ends
        fill_const(0);
        mem[0] = 12'hFFF;
        mem[N-1] = 12'hFFF;
        run_frame();
        check("ends_model_num", exp_num, 0);
        check("ends_num", int'(bus.detect_peak_num), 0);
        sweep_and_release();

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            fill_random(r % 4);
            run_frame();
            sweep_and_release();
        end

        // abort at scan address 500, then a clean rerun
        fill_random(0);
        bus.detect_start = 1'b0;
        tick(); tick();
        bus.detect_start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < N + 8 && !found; c++) begin
            tick();
            if (bus.bram_rd_addr == AW'(500)) found = 1'b1;
        end
        check("abort_reach_500", int'(found), 1);
        bus.detect_start = 1'b0;
        fin = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.detect_finish !== 1'b0) fin = 1'b1;
        end
        check("abort_no_finish", int'(fin), 0);
        check("abort_num_clear", int'(bus.detect_peak_num), 0);
        read_lit("abort_idx0", 0, 0, 0);
        run_frame();
        sweep_and_release();

        // reset pulse mid-scan with start held high
        fill_random(3);
        bus.detect_start = 1'b0;
        tick(); tick();
        bus.detect_start = 1'b1;
        repeat (300) tick();
        check("midscan_addr", int'(bus.bram_rd_addr), 299);
        rst = 1'b1;
        bus.peak_idx = 3'd0;
        tick();
        check("midrst_finish", int'(bus.detect_finish), 0);
        check("midrst_addr", int'(bus.bram_rd_addr), 0);
        check("midrst_num", int'(bus.detect_peak_num), 0);
        check("midrst_pos", int'(bus.peak_pos), 0);
        check("midrst_val", int'(bus.peak_val), 0);
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < N + 20; c++) begin
            tick();
            if (bus.bram_rd_addr != '0 || bus.detect_finish !== 1'b0) bad = 1'b1;
        end
        check("midrst_no_restart", int'(bad), 0);
        check("midrst_num_after", int'(bus.detect_peak_num), 0);
        run_frame();
        sweep_and_release();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_detect.md
PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 Parameter ADDR_W, default 10; BRAM address width, N = 2**ADDR_W samples per frame.
REQ-002 Parameter DATA_W, default 12; unsigned sample width.
REQ-003 Parameter MAX_PEAKS, default 6; size of the ranked peak table.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 detect_start  in  1  level; high while the system is in RUNNING.
REQ-007 detect_finish  out  1  level; high from scan completion until detect_start falls.
REQ-008 bram_rd_addr  out  ADDR_W  sample read address.
REQ-009 bram_rd_data  in  DATA_W  sample data, valid exactly 1 cycle after the address.
REQ-010 detect_peak_num  out  3  number of valid table entries, 0..MAX_PEAKS.
REQ-011 peak_idx  in  3  rank selector from display control; 0 = largest.
REQ-012 peak_pos  out  ADDR_W  address of the selected peak.
REQ-013 peak_val  out  DATA_W  value of the selected peak.

Function
REQ-014 FSM states: IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE->SCAN on a detect_start rising edge (registered previous value low, current value high); the table and count clear on the same edge.
REQ-016 SCAN: bram_rd_addr runs 0..N-1, one address per cycle; after N-1 is issued, go to DRAIN.
REQ-017 DRAIN: hold for the remaining pipeline cycles until sample N-1 has been evaluated; then go to DONE and assert detect_finish.
REQ-018 DONE: hold results and detect_finish; when detect_start is low, go to IDLE and deassert detect_finish; results persist.
REQ-019 Window: a 3-sample shift register (s[i-1], s[i], s[i+1]) is loaded from returned data.
REQ-020 Peak at i: 1 <= i <= N-2, s[i-1] < s[i] and s[i] >= s[i+1]; a plateau counts once, at its left edge.
REQ-021 Addresses 0 and N-1 are never peaks; no wrap-around between frame ends.
REQ-022 Table: sorted descending by value, at most one insertion per cycle.
REQ-023 A candidate is inserted only if it is strictly greater than an entry or the table is not full; lower entries shift down and the last entry drops when full.
REQ-024 Ties rank the earlier address higher.
REQ-025 detect_peak_num increments on each insertion and saturates at MAX_PEAKS.
REQ-026 Latency: detect_finish rises within N+4 cycles of the detect_start rising edge.
REQ-027 peak_pos/peak_val are combinational from the table by peak_idx.
REQ-028 Both read as 0 when peak_idx >= detect_peak_num, or when peak_idx >= MAX_PEAKS (covers idx 7 from display control).
REQ-029 Abort: detect_start low in SCAN or DRAIN -> IDLE next cycle; table and count cleared; detect_finish stays low.
REQ-030 bram_rd_addr holds 0 outside SCAN.

Reset
REQ-031 rst high: state IDLE, detect_finish 0, bram_rd_addr 0, detect_peak_num 0, all table entries 0, window 0, start-edge register 0.
REQ-032 rst has priority over all other inputs, including mid-scan; no residual peaks remain after release.
REQ-033 If detect_start is already high at rst release, this is not a rising edge; scanning waits for a fresh rising edge.

Structure
REQ-034 Shared package peak_pkg holds ADDR_W, DATA_W, MAX_PEAKS, the FSM state encoding and the peak-entry record type {pos, val}.
REQ-035 Sub-module peak_topk holds the sorted insertion table, clear, insert, count and indexed read; peak_detect holds the FSM, address counter and window.

Verification
REQ-036 Flat memory, all 0x100 -> detect_finish within N+4 cycles; detect_peak_num 0; peak_val 0 for every peak_idx.
REQ-037 Single spike, addr 100 = 0x800, others 0 -> num 1; idx0 gives pos 100, val 0x800; idx1 gives 0.
REQ-038 Eight spikes at addrs 10..80 step 10, values 0x10..0x80 -> num 6; idx0 = (80, 0x80) through idx5 = (30, 0x30).
REQ-039 Plateau 0x200 at addrs 50..52 plus equal spike 0x200 at 300 -> num 2; idx0 pos 50, idx1 pos 300.
REQ-040 Spikes at addr 0 and N-1 only -> num 0.
REQ-041 detect_start low at scan address 500, then a new rising edge -> first run gives no detect_finish; second run gives correct results.
REQ-042 rst pulse mid-scan -> all outputs at reset values next cycle; with detect_start still high, no scan starts until the next rising edge.
